// File: rtl/aes_ctrl_pkg.sv
// ============================================================================
// aes_ctrl_pkg : shared FSM states, round counts and key-length codes
// Rev 1.0
// ============================================================================
`default_nettype none

package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;

    localparam logic [1:0] KEY_LEN_128 = 2'd0;
    localparam logic [1:0] KEY_LEN_192 = 2'd1;
    localparam logic [1:0] KEY_LEN_256 = 2'd2;

    // The reserved code 3 falls back to the 128-bit round count.
    function automatic logic [3:0] nr_for_key_len(input logic [1:0] code);
        logic [3:0] nr;
        case (code)
            KEY_LEN_192: nr = 4'(NR_192);
            KEY_LEN_256: nr = 4'(NR_256);
            default:     nr = 4'(NR_128);
        endcase
        return nr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_counter.sv
// ============================================================================
// aes_round_counter : round index with clear, saturating increment, and
//                     terminal-count flag (index == NR-1). Rev 1.0
// ============================================================================
`default_nettype none

module aes_round_counter
    import aes_ctrl_pkg::*;
#(
    parameter int RND_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [RND_W-1:0] nr_i,
    output logic [RND_W-1:0] cnt_o,
    output logic             last_o
);

    logic [RND_W-1:0] cnt_q;
    logic [RND_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != nr_i)) begin
            cnt_d = cnt_q + RND_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == (nr_i - RND_W'(1)));

endmodule

`default_nettype wire

// File: rtl/aes_cipher_controller.sv
// ============================================================================
// aes_cipher_controller : AES encipher sequencing FSM (INIT, NR rounds, DONE).
// Optional macro AES_CIPHER_KEY256_EN adds key_len and 192/256-bit round counts.
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_cipher_controller
    import aes_ctrl_pkg::*;
#(
    parameter int RND_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             in_ready,
    output logic             load_en,
    output logic             round_en,
    output logic             rkey_en,
    output logic             mix_en,
    output logic [RND_W-1:0] round_num,
    output logic             out_valid,
    input  logic             out_ready
`ifdef AES_CIPHER_KEY256_EN
    ,
    input  logic [1:0]       key_len
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [RND_W-1:0] nr;
    logic             cnt_last;
    logic             cnt_clr;
    logic             cnt_inc;

`ifdef AES_CIPHER_KEY256_EN
    logic [RND_W-1:0] nr_q;

    // Round count is latched on the accept edge and held for the whole block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nr_q <= RND_W'(NR_128);
        end else if ((state_q == ST_IDLE) && start) begin
            nr_q <= RND_W'(nr_for_key_len(key_len));
        end
    end

    assign nr = nr_q;
`else
    assign nr = RND_W'(NR_128);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)     state_d = ST_INIT;
            ST_INIT:                 state_d = ST_ROUND;
            ST_ROUND: if (cnt_last)  state_d = ST_FINAL;
            ST_FINAL:                state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Strobes depend on the state register alone so input glitches never reach them.
    always_comb begin
        in_ready  = 1'b0;
        load_en   = 1'b0;
        round_en  = 1'b0;
        rkey_en   = 1'b0;
        mix_en    = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE:  in_ready = 1'b1;
            ST_INIT:  load_en  = 1'b1;
            ST_ROUND: begin
                round_en = 1'b1;
                rkey_en  = 1'b1;
                mix_en   = 1'b1;
            end
            ST_FINAL: begin
                round_en = 1'b1;
                rkey_en  = 1'b1;
            end
            ST_DONE:  out_valid = 1'b1;
            default:  in_ready  = 1'b0;
        endcase
    end

    assign cnt_inc = (state_q == ST_INIT) || (state_q == ST_ROUND);
    assign cnt_clr = (state_q == ST_DONE) && out_ready;

    aes_round_counter #(
        .RND_W (RND_W)
    ) u_round_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .nr_i   (nr),
        .cnt_o  (round_num),
        .last_o (cnt_last)
    );

endmodule

`default_nettype wire

// File: tb/tb_aes_cipher_controller.sv
// ============================================================================
// tb_aes_cipher_controller : cycle-by-cycle check of the controller against a
// timeline model derived from the round count. Rev 1.0
// ============================================================================
`default_nettype none

module tb_aes_cipher_controller;

    localparam int RND_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             out_ready;
    logic [1:0]       key_len;
    logic             in_ready;
    logic             load_en;
    logic             round_en;
    logic             rkey_en;
    logic             mix_en;
    logic [RND_W-1:0] round_num;
    logic             out_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_cipher_controller #(
        .RND_W (RND_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_ready  (in_ready),
        .load_en   (load_en),
        .round_en  (round_en),
        .rkey_en   (rkey_en),
        .mix_en    (mix_en),
        .round_num (round_num),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef AES_CIPHER_KEY256_EN
        ,
        .key_len   (key_len)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nr_of(input logic [1:0] code);
`ifdef AES_CIPHER_KEY256_EN
        if (code == 2'd1) return 12;
        if (code == 2'd2) return 14;
        return 10;
`else
        return (code == 2'd0) ? 10 : 10;
`endif
    endfunction

    // k = cycles since the accepting edge (0 = idle). Cycle 1 loads,
    // cycles 2..nr+1 are rounds 1..nr, from nr+2 the result is valid.
    task automatic expect_phase(input int k, input int nr, input string where);
        bit idle, init, rnd, done;
        int rn;
        idle = (k == 0);
        init = (k == 1);
        rnd  = (k >= 2) && (k <= nr + 1);
        done = (k >= nr + 2);
        rn   = rnd ? (k - 1) : (done ? nr : 0);
        chk($sformatf("%s k=%0d in_ready", where, k),  in_ready,  idle);
        chk($sformatf("%s k=%0d load_en", where, k),   load_en,   init);
        chk($sformatf("%s k=%0d round_en", where, k),  round_en,  rnd);
        chk($sformatf("%s k=%0d rkey_en", where, k),   rkey_en,   rnd);
        chk($sformatf("%s k=%0d mix_en", where, k),    mix_en,    rnd && (rn < nr));
        chk($sformatf("%s k=%0d round_num", where, k), round_num, rn);
        chk($sformatf("%s k=%0d out_valid", where, k), out_valid, done);
    endtask

    // Called at a negedge while idle; returns at a negedge, idle again.
    // Inputs toggle randomly while busy; they must be ignored.
    task automatic run_block(input logic [1:0] code, input int hold, input string where);
        int nr;
        nr        = nr_of(code);
        start     = 1'b1;
        key_len   = code;
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int k = 1; k <= nr + 2 + hold; k++) begin
            expect_phase(k, nr, where);
            start   = 1'($urandom_range(0, 1));
            key_len = 2'($urandom_range(0, 3));
            if (k >= nr + 2) out_ready = (k == nr + 2 + hold);
            else             out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b0;
        expect_phase(0, nr, {where, "/idle"});
    endtask

    initial begin
        start     = 1'b0;
        out_ready = 1'b0;
        key_len   = 2'd0;
        rst       = 1'b0;
        #1 rst    = 1'b1;
        #2 expect_phase(0, 10, "async_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            expect_phase(0, 10, "idle");
        end

        run_block(2'd0, 0, "aes128");
        run_block(2'd0, 5, "hold5");
        repeat (3) run_block(2'd0, 0, "b2b");

`ifdef AES_CIPHER_KEY256_EN
        run_block(2'd2, 0, "aes256");
        run_block(2'd1, 2, "aes192");
        run_block(2'd3, 0, "code3");
`endif

        repeat (6) run_block(2'($urandom_range(0, 3)), $urandom_range(0, 3), "rand");

        // Abort a block at round 5 with an asynchronous reset.
        start   = 1'b1;
        key_len = 2'd0;
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            expect_phase(k, 10, "pre_abort");
            if (k < 6) @(negedge clk);
        end
        #1 rst = 1'b1;
        #1 expect_phase(0, 10, "mid_reset");
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (14) begin
            @(negedge clk);
            expect_phase(0, 10, "after_abort");
        end

        run_block(2'd0, 1, "recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_cipher_controller.md
AES_CIPHER_CONTROLLER -- requirements
Module: aes_cipher_controller

Interface
REQ-001 Parameter: RND_W, default 4, width of round_num; SHALL be at least 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to encipher one block; accepted only when in_ready=1.
REQ-005 in_ready  output  1  controller idle and able to accept start.
REQ-006 load_en  output  1  datapath loads plaintext and performs initial AddRoundKey (key 0).
REQ-007 round_en  output  1  datapath performs one cipher round this cycle.
REQ-008 rkey_en  output  1  key expander advances one round key this cycle.
REQ-009 mix_en  output  1  MixColumns active; 0 in the final round.
REQ-010 round_num  output  RND_W  current round index.
REQ-011 out_valid  output  1  ciphertext in datapath is valid.
REQ-012 out_ready  input  1  consumer accepts ciphertext.
REQ-013 key_len  input  2  key length code (0=128, 1=192, 2=256); present only with AES_CIPHER_KEY256_EN.

Function
REQ-014 FSM states IDLE, INIT, ROUND, FINAL, DONE; state held in a register.
REQ-015 IDLE: in_ready=1; start=1 -> INIT; otherwise stay.
REQ-016 INIT: one cycle; load_en=1, round_num=0; -> ROUND.
REQ-017 ROUND: round_en=1, rkey_en=1, mix_en=1; round_num increments each cycle, from 1 up to NR-1; after round_num=NR-1 -> FINAL.
REQ-018 FINAL: one cycle; round_en=1, rkey_en=1, mix_en=0, round_num=NR; -> DONE.
REQ-019 DONE: out_valid=1; stay until out_ready=1, then -> IDLE with round_num cleared to 0.
REQ-020 Latency: start accepted at edge T -> out_valid first high in cycle T+NR+2; held until accepted.
REQ-021 in_ready, load_en, round_en, rkey_en, mix_en and out_valid SHALL be decoded from the state register only; they SHALL be glitch-free with respect to inputs.
REQ-022 start while not IDLE: ignored, with no queuing.
REQ-023 out_ready while not DONE: ignored.
REQ-024 out_ready=1 on the first DONE cycle: leave DONE after exactly one cycle; start in the following IDLE cycle is accepted.
REQ-025 round_num SHALL never exceed NR and never wrap; in IDLE and INIT it equals 0.
REQ-026 At most one of load_en and round_en is high in any cycle.

Reset
REQ-027 rst=1 forces IDLE immediately, regardless of clock.
REQ-028 On reset: round_num=0, in_ready=1, and load_en, round_en, rkey_en, mix_en, out_valid all 0.
REQ-029 Reset mid-operation (any state) aborts the block; no out_valid is produced for it.

Configuration
REQ-030 Macro AES_CIPHER_KEY256_EN.
REQ-031 Defined: key_len port exists and is sampled on the start-accept edge; NR=10/12/14 for codes 0/1/2; code 3 is treated as 0; NR is held constant until return to IDLE.
REQ-032 Undefined: no key_len port; NR fixed at 10.

Structure
REQ-033 Shared package aes_ctrl_pkg holds the state enumeration, the NR constants (10/12/14) and the key_len codes.
REQ-034 One sub-module, aes_round_counter, implements the round counter: clear, increment, and terminal-count compare against NR.

Verification
REQ-035 Reset, then start pulse at edge T with 128-bit key -> load_en in T+1, round_en in T+2..T+11, mix_en=0 only at round_num=10, out_valid from T+12.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, round_num stays 10; out_ready=1 -> IDLE next cycle, round_num=0.
REQ-037 Assert start continuously while busy -> exactly one block processed; second start accepted only in IDLE after DONE.
REQ-038 Assert rst at round_num=5 -> all enables 0 and round_num=0 immediately; out_valid never asserted for that block.
REQ-039 With AES_CIPHER_KEY256_EN, key_len=2 -> final round at round_num=14, out_valid at T+16; key_len=1 -> out_valid at T+14; key_len=3 behaves as 0.
REQ-040 Back-to-back: out_ready tied 1 and start tied 1 -> blocks complete every NR+3 cycles.
